// File: rtl/servisia_gpo_shifter.sv
// servisia_gpo_shifter
//
// Drives a 74HC595-style shift-register chain (SER/SRCLK/RCLK) from the parallel
// gpio_o word of servisia_gpo. Any change on gpio_i starts a transfer. A transfer
// shifts the word out MSB first and then pulses the storage latch. One transfer is
// forced after reset so that the chain always holds a defined value.
//
// Parameters:
//   WIDTH  number of bits in the chain (>= 1)
//   DIV    wb_clk_i cycles per SRCLK half-period and per latch pulse (>= 1)
//
// Ports:
//   wb_clk_i    in   1      system clock, rising edge
//   wb_rst_i    in   1      synchronous active-high reset
//   gpio_i      in   WIDTH  parallel word to mirror onto the chain
//   sr_oe_n_o   out  1      chain output enable, active low (optional, see below)
//   sr_ser_o    out  1      serial data to chain SER
//   sr_clk_o    out  1      shift clock to chain SRCLK
//   sr_latch_o  out  1      storage latch to chain RCLK
//   busy_o      out  1      high while a transfer is in progress
//
// Build option:
//   SERVISIA_GPO_SHIFTER_OE_EN  adds sr_oe_n_o. It resets to 1 and drops to 0 when
//   the first transfer after reset completes, so the chain outputs stay tri-stated
//   until valid data has been latched.
//
// All outputs are registered: every output register is loaded with the value that
// belongs to the state being entered.

module servisia_gpo_shifter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [WIDTH-1:0] gpio_i,
`ifdef SERVISIA_GPO_SHIFTER_OE_EN
    output logic             sr_oe_n_o,
`endif
    output logic             sr_ser_o,
    output logic             sr_clk_o,
    output logic             sr_latch_o,
    output logic             busy_o
);

    localparam int unsigned DivCntW = $clog2(DIV + 1);
    localparam int unsigned BitCntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StHigh,
        StLatch
    } state_e;

    state_e             r_state;
    logic [WIDTH-1:0]   r_shreg;
    logic [WIDTH-1:0]   r_snap;
    logic [WIDTH-1:0]   r_sent;
    logic               r_pend;
    logic [DivCntW-1:0] r_div_cnt;
    logic [BitCntW-1:0] r_bit_cnt;
    logic               r_ser;
    logic               r_clk;
    logic               r_latch;
    logic               r_busy;

    state_e             w_state_d;
    logic [WIDTH-1:0]   w_shreg_d;
    logic [WIDTH-1:0]   w_snap_d;
    logic [WIDTH-1:0]   w_sent_d;
    logic               w_pend_d;
    logic [DivCntW-1:0] w_div_cnt_d;
    logic [BitCntW-1:0] w_bit_cnt_d;
    logic               w_ser_d;
    logic               w_clk_d;
    logic               w_latch_d;
    logic               w_busy_d;

    logic               w_div_last;
    logic [WIDTH-1:0]   w_shreg_shl;

    assign w_div_last  = (r_div_cnt == DivCntW'(DIV - 1));
    assign w_shreg_shl = r_shreg << 1;

`ifdef SERVISIA_GPO_SHIFTER_OE_EN
    logic r_oe_n;
    logic w_oe_n_d;
`endif

    always_comb begin
        w_state_d   = r_state;
        w_shreg_d   = r_shreg;
        w_snap_d    = r_snap;
        w_sent_d    = r_sent;
        w_pend_d    = r_pend;
        w_div_cnt_d = r_div_cnt;
        w_bit_cnt_d = r_bit_cnt;
        w_ser_d     = r_ser;
        w_clk_d     = r_clk;
        w_latch_d   = r_latch;
        w_busy_d    = r_busy;
`ifdef SERVISIA_GPO_SHIFTER_OE_EN
        w_oe_n_d    = r_oe_n;
`endif

        unique case (r_state)
            StIdle: begin
                if (r_pend || (gpio_i != r_sent)) begin
                    // Snapshot the word; later gpio_i changes wait for the next IDLE.
                    w_shreg_d   = gpio_i;
                    w_snap_d    = gpio_i;
                    w_pend_d    = 1'b0;
                    w_bit_cnt_d = BitCntW'(WIDTH - 1);
                    w_div_cnt_d = '0;
                    w_ser_d     = gpio_i[WIDTH-1];
                    w_clk_d     = 1'b0;
                    w_busy_d    = 1'b1;
                    w_state_d   = StSetup;
                end
            end

            StSetup: begin
                if (w_div_last) begin
                    w_div_cnt_d = '0;
                    w_clk_d     = 1'b1;
                    w_state_d   = StHigh;
                end else begin
                    w_div_cnt_d = r_div_cnt + DivCntW'(1);
                end
            end

            StHigh: begin
                if (w_div_last) begin
                    w_div_cnt_d = '0;
                    w_clk_d     = 1'b0;
                    if (r_bit_cnt == '0) begin
                        w_latch_d = 1'b1;
                        w_state_d = StLatch;
                    end else begin
                        // SER changes together with the SRCLK fall, so it is stable
                        // across the whole SETUP+HIGH window of the next bit.
                        w_shreg_d   = w_shreg_shl;
                        w_ser_d     = w_shreg_shl[WIDTH-1];
                        w_bit_cnt_d = r_bit_cnt - BitCntW'(1);
                        w_state_d   = StSetup;
                    end
                end else begin
                    w_div_cnt_d = r_div_cnt + DivCntW'(1);
                end
            end

            StLatch: begin
                if (w_div_last) begin
                    w_div_cnt_d = '0;
                    w_latch_d   = 1'b0;
                    w_sent_d    = r_snap;
                    w_busy_d    = 1'b0;
`ifdef SERVISIA_GPO_SHIFTER_OE_EN
                    w_oe_n_d    = 1'b0;
`endif
                    w_state_d   = StIdle;
                end else begin
                    w_div_cnt_d = r_div_cnt + DivCntW'(1);
                end
            end

            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= StIdle;
            r_shreg   <= '0;
            r_snap    <= '0;
            r_sent    <= '0;
            r_pend    <= 1'b1;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_ser     <= 1'b0;
            r_clk     <= 1'b0;
            r_latch   <= 1'b0;
            r_busy    <= 1'b0;
`ifdef SERVISIA_GPO_SHIFTER_OE_EN
            r_oe_n    <= 1'b1;
`endif
        end else begin
            r_state   <= w_state_d;
            r_shreg   <= w_shreg_d;
            r_snap    <= w_snap_d;
            r_sent    <= w_sent_d;
            r_pend    <= w_pend_d;
            r_div_cnt <= w_div_cnt_d;
            r_bit_cnt <= w_bit_cnt_d;
            r_ser     <= w_ser_d;
            r_clk     <= w_clk_d;
            r_latch   <= w_latch_d;
            r_busy    <= w_busy_d;
`ifdef SERVISIA_GPO_SHIFTER_OE_EN
            r_oe_n    <= w_oe_n_d;
`endif
        end
    end

    assign sr_ser_o   = r_ser;
    assign sr_clk_o   = r_clk;
    assign sr_latch_o = r_latch;
    assign busy_o     = r_busy;
`ifdef SERVISIA_GPO_SHIFTER_OE_EN
    assign sr_oe_n_o  = r_oe_n;
`endif

endmodule

// File: tb/tb_servisia_gpo_shifter.sv
// tb_servisia_gpo_shifter
//
// Directed bench for servisia_gpo_shifter (WIDTH=8, DIV=2). Stimulus pushes the word
// each RCLK pulse must deliver into a queue; a monitor models the 74HC595 chain and
// pops/compares on every RCLK rising edge.

module tb_servisia_gpo_shifter;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DIV   = 2;
    localparam int unsigned XFER_BUSY = 2 * DIV * WIDTH + DIV;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] gpio = '0;
    logic             ser;
    logic             srclk;
    logic             latch;
    logic             busy;
`ifdef SERVISIA_GPO_SHIFTER_OE_EN
    logic             oe_n;
`endif

    servisia_gpo_shifter #(
        .WIDTH(WIDTH),
        .DIV  (DIV)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .gpio_i    (gpio),
`ifdef SERVISIA_GPO_SHIFTER_OE_EN
        .sr_oe_n_o (oe_n),
`endif
        .sr_ser_o  (ser),
        .sr_clk_o  (srclk),
        .sr_latch_o(latch),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_latches = 0;
    int n_clk_rises = 0;
    logic [WIDTH-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait until busy has been low for 3 consecutive cycles (bounded).
    task automatic wait_idle(input string name);
        int quiet = 0;
        int cyc = 0;
        while (quiet < 3 && cyc < 400) begin
            step(1);
            cyc++;
            quiet = busy ? 0 : quiet + 1;
        end
        check({name, " idle reached"}, 32'(quiet >= 3), 32'd1);
    endtask

    // Chain model and scoreboard.
    task automatic monitor();
        logic [WIDTH-1:0] chain = '0;
        logic [WIDTH-1:0] expw;
        logic prev_clk = 1'b0;
        logic prev_latch = 1'b0;
        int pulses = 0;
        int lat_w = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pulses = 0;
                prev_clk = 1'b0;
                prev_latch = 1'b0;
                lat_w = 0;
            end else begin
                if (srclk && !prev_clk) begin
                    chain = {chain[WIDTH-2:0], ser};
                    pulses++;
                    n_clk_rises++;
                end
                if (latch && !prev_latch) begin
                    n_latches++;
                    lat_w = 0;
                    check("srclk pulses per latch", 32'(pulses), 32'(WIDTH));
                    pulses = 0;
                    if (exp_q.size() == 0) begin
                        check("unexpected latch word", 32'(chain), 32'hdead);
                    end else begin
                        expw = exp_q.pop_front();
                        check("latched word", 32'(chain), 32'(expw));
                    end
                end
                if (latch) lat_w++;
                if (!latch && prev_latch) begin
                    check("latch width", 32'(lat_w), 32'(DIV));
`ifdef SERVISIA_GPO_SHIFTER_OE_EN
                    check("oe_n at latch fall", 32'(oe_n), 32'd0);
`endif
                end
                prev_clk = srclk;
                prev_latch = latch;
            end
        end
    endtask

    initial begin
        int cnt;
        int base;
        fork
            monitor();
        join_none

        // 1: reset, gpio=0, forced transfer.
        step(3);
        check("reset ser", 32'(ser), 32'd0);
        check("reset srclk", 32'(srclk), 32'd0);
        check("reset latch", 32'(latch), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
`ifdef SERVISIA_GPO_SHIFTER_OE_EN
        check("reset oe_n", 32'(oe_n), 32'd1);
`endif
        exp_q.push_back(8'h00);
        rst = 1'b0;
        check("busy before detect", 32'(busy), 32'd0);
        step(1);
        check("busy after detect", 32'(busy), 32'd1);
`ifdef SERVISIA_GPO_SHIFTER_OE_EN
        check("oe_n during first xfer", 32'(oe_n), 32'd1);
`endif
        cnt = 1;
        while (busy && cnt < 200) begin
            step(1);
            if (busy) cnt++;
        end
        check("busy cycles", 32'(cnt), 32'(XFER_BUSY));
`ifdef SERVISIA_GPO_SHIFTER_OE_EN
        check("oe_n after first xfer", 32'(oe_n), 32'd0);
`endif
        check("t1 latches", 32'(n_latches), 32'd1);
        check("t1 srclk rises", 32'(n_clk_rises), 32'd8);
        step(20);
        check("t1 idle srclk rises", 32'(n_clk_rises), 32'd8);
        check("t1 idle latches", 32'(n_latches), 32'd1);
        check("t1 idle busy", 32'(busy), 32'd0);

        // 2: A5 from idle.
        gpio = 8'hA5;
        exp_q.push_back(8'hA5);
        wait_idle("t2");
        check("t2 latches", 32'(n_latches), 32'd2);

        // 3: 01 then FF mid-transfer.
        gpio = 8'h01;
        exp_q.push_back(8'h01);
        step(10);
        gpio = 8'hFF;
        exp_q.push_back(8'hFF);
        wait_idle("t3");
        check("t3 latches", 32'(n_latches), 32'd4);

        // 4: bring sent to 00, then 3C->00 mid-transfer, then a glitch 00->11->00.
        gpio = 8'h00;
        exp_q.push_back(8'h00);
        wait_idle("t4 pre");
        base = n_latches;
        gpio = 8'h3C;
        exp_q.push_back(8'h3C);
        step(10);
        gpio = 8'h00;
        exp_q.push_back(8'h00);
        cnt = 0;
        while (n_latches == base && cnt < 100) begin
            step(1);
            cnt++;
        end
        check("t4 first latch seen", 32'(n_latches), 32'(base + 1));
        step(8);
        check("t4 second xfer busy", 32'(busy), 32'd1);
        gpio = 8'h11;
        step(3);
        gpio = 8'h00;
        wait_idle("t4");
        step(10);
        check("t4 latches", 32'(n_latches), 32'(base + 2));

        // 5: reset during bit 4 of a transfer.
        base = n_latches;
        gpio = 8'hC3;
        step(15);
        check("t5 srclk high before reset", 32'(srclk), 32'd1);
        rst = 1'b1;
        step(1);
        check("t5 srclk after reset", 32'(srclk), 32'd0);
        check("t5 latch after reset", 32'(latch), 32'd0);
        check("t5 busy after reset", 32'(busy), 32'd0);
`ifdef SERVISIA_GPO_SHIFTER_OE_EN
        check("t5 oe_n after reset", 32'(oe_n), 32'd1);
`endif
        check("t5 no latch for aborted word", 32'(n_latches), 32'(base));
        exp_q.push_back(8'hC3);
        rst = 1'b0;
        wait_idle("t5");
        check("t5 latches", 32'(n_latches), 32'(base + 1));
`ifdef SERVISIA_GPO_SHIFTER_OE_EN
        check("t5 oe_n after forced xfer", 32'(oe_n), 32'd0);
`endif

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
